// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store buffer: size codes, queued entry layout, full strobe.
package dmem_pkg;

    localparam int WB_AW = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] STRB_ALL = 4'b1111;

    typedef struct packed {
        logic [WB_AW-1:2] addr;
        logic [31:0]      data;
        logic [3:0]       strb;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_store_buffer_lane_steer.sv
// Combinational lane steering for CPU stores: replicates right-justified data onto byte lanes,
// builds the write strobe and flags misaligned or reserved-size stores.
module store_lane_steer
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misalign_o
);

    always_comb begin
        wdata_o    = data_i;
        wstrb_o    = 4'b0000;
        misalign_o = 1'b0;
        case (size_e'(size_i))
            SZ_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            SZ_HALF: begin
                wdata_o    = {2{data_i[15:0]}};
                wstrb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                wstrb_o    = STRB_ALL;
                misalign_o = |addr_lo_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the MEM-stage store path and data memory: steered stores queued in a FIFO.
// Optional same-cycle bypass of an empty buffer is enabled by defining DMEM_WBUF_BYPASS_EN.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          empty,
    output logic          full,
    output logic          err_misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (AW != WB_AW) begin : g_aw_check
        $error("dmem_store_buffer: AW must equal dmem_pkg::WB_AW");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    wbuf_entry_t   fifo_q [DEPTH];

    logic [31:0]   steer_wdata;
    logic [3:0]    steer_wstrb;
    logic          steer_misalign;
    wbuf_entry_t   push_entry, out_entry;
    logic          push_acc, push_ok, wr_en, rd_en;

    store_lane_steer u_steer (
        .addr_lo_i  (st_addr[1:0]),
        .data_i     (st_data),
        .size_i     (st_size),
        .wdata_o    (steer_wdata),
        .wstrb_o    (steer_wstrb),
        .misalign_o (steer_misalign)
    );

    assign push_entry = '{addr: st_addr[AW-1:2], data: steer_wdata, strb: steer_wstrb};

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign push_acc = st_valid & st_ready;
    assign push_ok  = push_acc & !steer_misalign;

`ifdef DMEM_WBUF_BYPASS_EN
    logic bypass;
    assign bypass     = empty & push_ok;
    assign mem_wvalid = !empty | bypass;
    // A bypassed store that the memory takes immediately never occupies a slot.
    assign wr_en      = push_ok & !(bypass & mem_wready);
    always_comb begin
        out_entry = '0;
        if (bypass)
            out_entry = push_entry;
        else if (!empty)
            out_entry = fifo_q[rd_ptr_q];
    end
`else
    assign mem_wvalid = !empty;
    assign wr_en      = push_ok;
    always_comb begin
        out_entry = '0;
        if (!empty)
            out_entry = fifo_q[rd_ptr_q];
    end
`endif

    assign rd_en     = !empty & mem_wready;
    assign mem_waddr = {out_entry.addr, 2'b00};
    assign mem_wdata = out_entry.data;
    assign mem_wstrb = out_entry.strb;
    assign err_misalign = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
        err_d    = push_acc & steer_misalign;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage carries data only; validity is tracked entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer (default build): vector table plus multi-cycle sequences.
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;
    logic        full;
    logic        err_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_size      (st_size),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .empty        (empty),
        .full         (full),
        .err_misalign (err_misalign)
    );

    typedef struct {
        logic        rst_n;
        logic        stv;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        wr;
        logic        e_wv;
        logic        e_empty;
        logic        e_full;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic w);
        rst_n = r; st_valid = v; st_addr = a; st_data = d; st_size = s; mem_wready = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input logic [31:0] a, input logic [31:0] d);
        chk({name, "_wvalid"}, 32'(mem_wvalid), 32'd1);
        chk({name, "_waddr"}, mem_waddr, a);
        chk({name, "_wdata"}, mem_wdata, d);
    endtask

    initial begin
        //          rst stv addr          data          sz    wr  wv emp ful rdy err waddr         wdata         strb
        vecs[0]  = '{0, 1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1, 0, 1, 0, 1, 0, 32'h0,         32'h0,         4'b0000};
        vecs[1]  = '{0, 1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1, 0, 1, 0, 1, 0, 32'h0,         32'h0,         4'b0000};
        vecs[2]  = '{1, 1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1, 1, 0, 0, 1, 0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
        vecs[3]  = '{1, 1, 32'h0000_2002, 32'h0000_1234, 2'b01, 1, 1, 0, 0, 1, 0, 32'h0000_2000, 32'h1234_1234, 4'b1100};
        vecs[4]  = '{1, 1, 32'h0000_2001, 32'hDEAD_BEEF, 2'b10, 1, 0, 1, 0, 1, 1, 32'h0,         32'h0,         4'b0000};
        vecs[5]  = '{1, 0, 32'h0000_0000, 32'h0000_0000, 2'b00, 1, 0, 1, 0, 1, 0, 32'h0,         32'h0,         4'b0000};
        vecs[6]  = '{1, 1, 32'h0000_3001, 32'h0000_5555, 2'b01, 1, 0, 1, 0, 1, 1, 32'h0,         32'h0,         4'b0000};
        vecs[7]  = '{1, 1, 32'h0000_3000, 32'h0000_5555, 2'b11, 1, 0, 1, 0, 1, 1, 32'h0,         32'h0,         4'b0000};
        vecs[8]  = '{1, 1, 32'h0000_4000, 32'h0000_005A, 2'b00, 0, 1, 0, 0, 1, 0, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0001};
        vecs[9]  = '{1, 1, 32'h0000_4000, 32'h0000_BEEF, 2'b01, 0, 1, 0, 0, 1, 0, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0001};
        vecs[10] = '{1, 0, 32'h0000_0000, 32'h0000_0000, 2'b00, 1, 1, 0, 0, 1, 0, 32'h0000_4000, 32'hBEEF_BEEF, 4'b0011};
        vecs[11] = '{1, 0, 32'h0000_0000, 32'h0000_0000, 2'b00, 1, 0, 1, 0, 1, 0, 32'h0,         32'h0,         4'b0000};
        vecs[12] = '{1, 1, 32'h0000_5004, 32'h1122_3344, 2'b10, 0, 1, 0, 0, 1, 0, 32'h0000_5004, 32'h1122_3344, 4'b1111};
        vecs[13] = '{1, 0, 32'h0000_0000, 32'h0000_0000, 2'b00, 1, 0, 1, 0, 1, 0, 32'h0,         32'h0,         4'b0000};
        vecs[14] = '{1, 1, 32'h0000_6001, 32'h0000_1277, 2'b00, 0, 1, 0, 0, 1, 0, 32'h0000_6000, 32'h7777_7777, 4'b0010};
        vecs[15] = '{1, 0, 32'h0000_0000, 32'h0000_0000, 2'b00, 1, 0, 1, 0, 1, 0, 32'h0,         32'h0,         4'b0000};

        drive(0, 0, 32'h0, 32'h0, 2'b00, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst_n, vecs[i].stv, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].wr);
            tick();
            chk($sformatf("v%0d_wvalid", i), 32'(mem_wvalid), 32'(vecs[i].e_wv));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_err", i), 32'(err_misalign), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].e_waddr);
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_strb));
        end

        // Fill to full with memory stalled; a fifth store must be held off.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b10, 0);
            tick();
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_st_ready", 32'(st_ready), 32'd0);
        drive(1, 1, 32'h20, 32'hA000_0004, 2'b10, 0);
        tick();
        chk("held_full", 32'(full), 32'd1);
        chk_head("held_head", 32'h10, 32'hA000_0000);
        drive(1, 0, 32'h0, 32'h0, 2'b00, 1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("drain%0d", i), 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            tick();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_wvalid", 32'(mem_wvalid), 32'd0);

        // Full with simultaneous pop and push request: only the pop happens.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i), 2'b10, 0);
            tick();
        end
        drive(1, 1, 32'h50, 32'hB000_0004, 2'b10, 1);
        tick();
        chk("popfull_full", 32'(full), 32'd0);
        chk_head("popfull_head", 32'h44, 32'hB000_0001);
        drive(1, 1, 32'h50, 32'hB000_0004, 2'b10, 0);
        tick();
        chk("repush_full", 32'(full), 32'd1);
        drive(1, 0, 32'h0, 32'h0, 2'b00, 1);
        for (int i = 1; i < 5; i++) begin
            chk_head($sformatf("drain_b%0d", i), 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            tick();
        end
        chk("drain_b_empty", 32'(empty), 32'd1);

        // Reset with entries queued discards them.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'h80 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'b10, 0);
            tick();
        end
        chk("preq_empty", 32'(empty), 32'd0);
        drive(0, 0, 32'h0, 32'h0, 2'b00, 0);
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("rst_waddr", mem_waddr, 32'h0);
        drive(1, 0, 32'h0, 32'h0, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_wvalid%0d", i), 32'(mem_wvalid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
